// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master bridge.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_t;

endpackage

// File: rtl/apb_access_timer.sv
// Watchdog for the APB ACCESS phase: counts stalled ACCESS cycles and flags
// the cycle that would be the TIMEOUT-th consecutive stall.
module apb_access_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt;

      // Stall counter, cleared when a new transfer enters SETUP
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          cnt <= '0;
        end else if (count) begin
          cnt <= cnt + 1'b1;
        end
      end

      // Expiry is flagged on the stalled cycle that brings the count to TIMEOUT,
      // so the bridge leaves ACCESS after exactly TIMEOUT stalled cycles.
      assign expired = count && (cnt == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: turns single valid/ready commands into APB SETUP/ACCESS
// transfers and returns the result on a valid/ready response port.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              P_clk,
  input  logic              P_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] P_addr,
  output logic              P_selx,
  output logic              P_enable,
  output logic              P_write,
  output logic [DATA_W-1:0] P_wdata,
  input  logic              P_ready,
  input  logic              P_slverr,
  input  logic [DATA_W-1:0] P_rdata
);

  apb_state_t state;
  logic       wd_clear;
  logic       wd_count;
  logic       wd_expired;

  assign wd_clear = (state == IDLE) && req_valid && req_ready;
  assign wd_count = (state == ACCESS) && !P_ready;

  apb_access_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (P_clk),
    .rst    (P_rst),
    .clear  (wd_clear),
    .count  (wd_count),
    .expired(wd_expired)
  );

  // Transfer sequencer with all outputs registered
  always_ff @(posedge P_clk) begin
    if (P_rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      P_addr      <= '0;
      P_selx      <= 1'b0;
      P_enable    <= 1'b0;
      P_write     <= 1'b0;
      P_wdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            P_addr    <= req_addr;
            P_write   <= req_write;
            P_wdata   <= req_wdata;
            P_selx    <= 1'b1;
            req_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          P_enable <= 1'b1;
          state    <= ACCESS;
        end
        ACCESS: begin
          // Slave completion takes priority over a watchdog expiry in the same cycle
          if (P_ready) begin
            rsp_rdata   <= P_write ? '0 : P_rdata;
            rsp_err     <= P_slverr;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            P_selx      <= 1'b0;
            P_enable    <= 1'b0;
            state       <= RESP;
          end else if (wd_expired) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            P_selx      <= 1'b0;
            P_enable    <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge with a small APB slave model.
module tb_apb_master_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          P_clk = 1'b0;
  logic          P_rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] P_addr;
  logic          P_selx;
  logic          P_enable;
  logic          P_write;
  logic [DW-1:0] P_wdata;
  logic          P_ready;
  logic          P_slverr;
  logic [DW-1:0] P_rdata;

  always #5 P_clk = ~P_clk;

  apb_master_bridge #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .P_clk      (P_clk),
    .P_rst      (P_rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .P_addr     (P_addr),
    .P_selx     (P_selx),
    .P_enable   (P_enable),
    .P_write    (P_write),
    .P_wdata    (P_wdata),
    .P_ready    (P_ready),
    .P_slverr   (P_slverr),
    .P_rdata    (P_rdata)
  );

  // Slave model: 4-word memory, programmable wait states, error, or hang.
  logic [31:0] mem [4];
  int unsigned wc = 0;
  int unsigned slv_waits = 0;
  bit          slv_err = 1'b0;
  bit          slv_hang = 1'b0;
  bit          mem_clr = 1'b1;

  always @(posedge P_clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else if (P_selx && P_enable && P_ready && P_write && !slv_err) begin
      mem[P_addr[1:0]] <= P_wdata;
    end
    if (!(P_selx && P_enable)) wc <= 0;
    else if (!P_ready) wc <= wc + 1;
  end

  assign P_ready  = P_selx && P_enable && !slv_hang && (wc >= slv_waits);
  assign P_slverr = slv_err;
  assign P_rdata  = (P_ready && !P_write) ? mem[P_addr[1:0]] : 32'hDEAD_BEEF;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned waits;
    bit          err;
    bit          hang;
    int unsigned hold;
    logic [31:0] e_rdata;
    bit          e_err;
    bit          e_to;
    int unsigned e_lat;
    int unsigned e_en;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          to;
  } rsp_t;

  vec_t vt[$];
  rsp_t sbq[$];
  int unsigned nvec = 0;
  int unsigned nmis = 0;

  function automatic vec_t mk(bit wr, logic [31:0] a, logic [31:0] d, int unsigned waits,
                              bit err, bit hang, int unsigned hold, logic [31:0] er,
                              bit ee, bit eto, int unsigned lat, int unsigned en);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.waits = waits; v.err = err; v.hang = hang;
    v.hold = hold; v.e_rdata = er; v.e_err = ee; v.e_to = eto; v.e_lat = lat; v.e_en = en;
    return v;
  endfunction

  task automatic tick();
    @(posedge P_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({pfx, "_ctrl"}, 64'({rsp_valid, rsp_err, rsp_timeout, P_selx, P_enable, P_write}), 64'd0);
    chk({pfx, "_p_addr"}, 64'(P_addr), 64'd0);
    chk({pfx, "_p_wdata"}, 64'(P_wdata), 64'd0);
    chk({pfx, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int unsigned cyc, en_cnt, sel_first, en_first, bad_hold;
    rsp_t exp, got;
    string pf;
    pf = $sformatf("v%0d", idx);
    chk({pf, "_req_ready_idle"}, 64'(req_ready), 64'd1);
    slv_waits = v.waits; slv_err = v.err; slv_hang = v.hang;
    rsp_ready = (v.hold == 0);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    exp.rdata = v.e_rdata; exp.err = v.e_err; exp.to = v.e_to;
    sbq.push_back(exp);
    tick();
    req_valid = 1'b0; req_addr = '1; req_wdata = '1;
    cyc = 1; en_cnt = 0; sel_first = 0; en_first = 0; bad_hold = 0;
    while (!rsp_valid && cyc < 100) begin
      if (P_selx && sel_first == 0) sel_first = cyc;
      if (P_enable) begin
        en_cnt++;
        if (en_first == 0) en_first = cyc;
      end
      if (P_selx && (P_addr != v.addr || P_write != v.wr || (v.wr && P_wdata != v.wdata)))
        bad_hold++;
      tick();
      cyc++;
    end
    chk({pf, "_rsp_latency"}, 64'(cyc), 64'(v.e_lat));
    if (!rsp_valid) begin
      void'(sbq.pop_front());
      return;
    end
    chk({pf, "_selx_rise"}, 64'(sel_first), 64'd1);
    chk({pf, "_enable_rise"}, 64'(en_first), 64'd2);
    chk({pf, "_enable_cycles"}, 64'(en_cnt), 64'(v.e_en));
    chk({pf, "_apb_stable"}, 64'(bad_hold), 64'd0);
    chk({pf, "_apb_idle_in_resp"}, 64'({P_selx, P_enable}), 64'd0);
    for (int unsigned i = 0; i < v.hold; i++) begin
      chk({pf, "_hold"}, {29'd0, rsp_valid, req_ready, rsp_err, rsp_timeout, rsp_rdata},
          {29'd0, 1'b1, 1'b0, v.e_err, v.e_to, v.e_rdata});
      tick();
    end
    rsp_ready = 1'b1;
    got.rdata = rsp_rdata; got.err = rsp_err; got.to = rsp_timeout;
    exp = sbq.pop_front();
    chk({pf, "_rsp_rdata"}, 64'(got.rdata), 64'(exp.rdata));
    chk({pf, "_rsp_err"}, 64'(got.err), 64'(exp.err));
    chk({pf, "_rsp_timeout"}, 64'(got.to), 64'(exp.to));
    tick();
    chk({pf, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
    slv_hang = 1'b0; slv_err = 1'b0; slv_waits = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int unsigned spurious;
    //      wr addr  wdata  wt er hg hd exp_rdata er to lat en
    vt.push_back(mk(1, 32'd0, 32'd11, 0, 0, 0, 0, 32'd0, 0, 0, 3, 1));
    vt.push_back(mk(1, 32'd1, 32'd22, 0, 0, 0, 0, 32'd0, 0, 0, 3, 1));
    vt.push_back(mk(0, 32'd1, 32'd0, 0, 0, 0, 0, 32'd22, 0, 0, 3, 1));
    vt.push_back(mk(0, 32'd0, 32'd0, 0, 0, 0, 0, 32'd11, 0, 0, 3, 1));
    vt.push_back(mk(1, 32'd2, 32'd33, 3, 0, 0, 0, 32'd0, 0, 0, 6, 4));
    vt.push_back(mk(0, 32'd2, 32'd0, 3, 0, 0, 0, 32'd33, 0, 0, 6, 4));
    vt.push_back(mk(0, 32'd2, 32'd0, 0, 0, 0, 5, 32'd33, 0, 0, 3, 1));
    vt.push_back(mk(0, 32'd1, 32'd0, 0, 1, 0, 0, 32'd22, 1, 0, 3, 1));
    vt.push_back(mk(1, 32'd3, 32'd44, 0, 1, 0, 0, 32'd0, 1, 0, 3, 1));
    vt.push_back(mk(0, 32'd3, 32'd0, 0, 0, 0, 0, 32'd0, 0, 0, 3, 1));
    vt.push_back(mk(0, 32'd0, 32'd0, 0, 0, 1, 0, 32'd0, 1, 1, 18, 16));
    vt.push_back(mk(1, 32'd1, 32'd55, 0, 0, 1, 0, 32'd0, 1, 1, 18, 16));
    vt.push_back(mk(0, 32'd1, 32'd0, 15, 0, 0, 0, 32'd22, 0, 0, 18, 16));
    vt.push_back(mk(0, 32'd1, 32'd0, 16, 0, 0, 0, 32'd0, 1, 1, 18, 16));

    P_rst = 1'b1; mem_clr = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    P_rst = 1'b0; mem_clr = 1'b0;
    tick();

    for (int i = 0; i < vt.size(); i++) run_vec(i, vt[i]);

    // Reset in the middle of an ACCESS phase drops the command silently
    slv_hang = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd0; req_wdata = 32'd99;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("midrst_in_access", 64'({P_selx, P_enable}), 64'd3);
    P_rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    P_rst = 1'b0; slv_hang = 1'b0;
    spurious = 0;
    repeat (20) begin
      if (rsp_valid) spurious++;
      tick();
    end
    chk("midrst_no_response", 64'(spurious), 64'd0);
    run_vec(100, mk(0, 32'd0, 32'd0, 0, 0, 0, 0, 32'd11, 0, 0, 3, 1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
